// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, transaction owner
// and a counter-width helper used by the arbiter and its priority block.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_t;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_priority.sv
// Winner selection between the CPU and the external port, with a saturating
// starvation counter that hands the external port priority after MAX_WAIT losses.
module arb_priority
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
)(
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_arb_en,
    input  logic   i_cpu_req,
    input  logic   i_ext_req,
    output logic   o_grant_valid,
    output owner_t o_grant_owner
);

    localparam int unsigned   WW       = cnt_width(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);

    logic [WW-1:0] r_wait_cnt;
    logic          w_ext_wins;

    // The CPU wins every tie until the external port has lost MAX_WAIT times.
    assign w_ext_wins    = i_ext_req & (~i_cpu_req | (r_wait_cnt == WAIT_SAT));
    assign o_grant_valid = i_arb_en & (i_cpu_req | i_ext_req);
    assign o_grant_owner = w_ext_wins ? OWN_EXT : OWN_CPU;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait_cnt <= '0;
        end else if (i_arb_en) begin
            if (!i_ext_req || w_ext_wins) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != WAIT_SAT) begin
                r_wait_cnt <= r_wait_cnt + WW'(1);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and the
// external loader/debug port, sequencing each access over MEM_LAT cycles.
//
//   state  | meaning
//   IDLE   | arbitrate; latch winner's request fields
//   ACCESS | drive memory for MEM_LAT cycles, capture read data on the last
//   RESP   | one-cycle done pulse to the owner
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned Nbits    = 64,
    parameter int unsigned MEM_LAT  = 2,
    parameter int unsigned MAX_WAIT = 4
)(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cpu_req,
    input  logic             i_cpu_we,
    input  logic [Nbits-1:0] i_cpu_addr,
    input  logic [Nbits-1:0] i_cpu_wdata,
    output logic [Nbits-1:0] o_cpu_rdata,
    output logic             o_cpu_done,
    output logic             o_cpu_stall,
    input  logic             i_ext_req,
    input  logic             i_ext_we,
    input  logic [Nbits-1:0] i_ext_addr,
    input  logic [Nbits-1:0] i_ext_wdata,
    output logic [Nbits-1:0] o_ext_rdata,
    output logic             o_ext_done,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic [Nbits-1:0] o_mem_addr,
    output logic [Nbits-1:0] o_mem_wdata,
    input  logic [Nbits-1:0] i_mem_rdata
);

    localparam int unsigned   LW       = cnt_width(MEM_LAT);
    localparam logic [LW-1:0] LAT_LAST = LW'(MEM_LAT - 1);
    localparam logic [LW-1:0] LAT_MAX  = LW'(MEM_LAT);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [LW-1:0]    r_lat_cnt;
    owner_t           r_owner;
    logic             r_we;
    logic [Nbits-1:0] r_addr;
    logic [Nbits-1:0] r_wdata;
    logic [Nbits-1:0] r_cpu_rdata;
    logic [Nbits-1:0] r_ext_rdata;

    logic             w_arb_en;
    logic             w_grant_valid;
    owner_t           w_grant_owner;
    logic             w_last_access;

    assign w_arb_en      = (r_state == IDLE);
    assign w_last_access = (r_state == ACCESS) && (r_lat_cnt == LAT_LAST);

    arb_priority #(
        .MAX_WAIT (MAX_WAIT)
    ) u_priority (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_arb_en      (w_arb_en),
        .i_cpu_req     (i_cpu_req),
        .i_ext_req     (i_ext_req),
        .o_grant_valid (w_grant_valid),
        .o_grant_owner (w_grant_owner)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        o_cpu_done  = 1'b0;
        o_ext_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                o_mem_read  = ~r_we;
                // A write commits in one cycle; the rest of the slot is dead time.
                o_mem_write = r_we & (r_lat_cnt == '0);
                if (w_last_access) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
                o_cpu_done  = (r_owner == OWN_CPU);
                o_ext_done  = (r_owner == OWN_EXT);
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lat_cnt   <= '0;
            r_owner     <= OWN_CPU;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_ext_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_owner   <= w_grant_owner;
                        r_lat_cnt <= '0;
                        if (w_grant_owner == OWN_EXT) begin
                            r_we    <= i_ext_we;
                            r_addr  <= i_ext_addr;
                            r_wdata <= i_ext_wdata;
                        end else begin
                            r_we    <= i_cpu_we;
                            r_addr  <= i_cpu_addr;
                            r_wdata <= i_cpu_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (r_lat_cnt != LAT_MAX) begin
                        r_lat_cnt <= r_lat_cnt + LW'(1);
                    end
                    if (w_last_access && !r_we) begin
                        if (r_owner == OWN_EXT) begin
                            r_ext_rdata <= i_mem_rdata;
                        end else begin
                            r_cpu_rdata <= i_mem_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Address and write data stay on the bus between accesses.
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_cpu_rdata = r_cpu_rdata;
    assign o_ext_rdata = r_ext_rdata;
    assign o_cpu_stall = i_cpu_req & ~o_cpu_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized checks of dmem_arbiter against a transaction-level
// model: each grant occupies the memory for MEM_LAT+2 cycles end to end.
module tb_dmem_arbiter;

    localparam int NB  = 64;
    localparam int LAT = 2;
    localparam int MW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, cpu_done, cpu_stall;
    logic [NB-1:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic          ext_req, ext_we, ext_done;
    logic [NB-1:0] ext_addr, ext_wdata, ext_rdata;
    logic          mem_read, mem_write;
    logic [NB-1:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .Nbits    (NB),
        .MEM_LAT  (LAT),
        .MAX_WAIT (MW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cpu_req   (cpu_req),
        .i_cpu_we    (cpu_we),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .o_cpu_rdata (cpu_rdata),
        .o_cpu_done  (cpu_done),
        .o_cpu_stall (cpu_stall),
        .i_ext_req   (ext_req),
        .i_ext_we    (ext_we),
        .i_ext_addr  (ext_addr),
        .i_ext_wdata (ext_wdata),
        .o_ext_rdata (ext_rdata),
        .o_ext_done  (ext_done),
        .o_mem_read  (mem_read),
        .o_mem_write (mem_write),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    // Memory stand-in: a fixed word for directed reads, else a hash of the address.
    bit            fixed_mode;
    logic [NB-1:0] fixed_rdata;

    function automatic logic [NB-1:0] mem_fn(input logic [NB-1:0] a);
        return {a[31:0] ^ 32'hC0DE_1234, ~a[63:32]};
    endfunction

    assign mem_rdata = fixed_mode ? fixed_rdata : mem_fn(mem_addr);

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference model state
    int            m_rem;
    bit            m_ext;
    bit            m_we;
    logic [NB-1:0] m_addr, m_wdata, m_cpu_rd, m_ext_rd;
    int            m_wc;

    // Requester drivers and observations
    bit            pend_c, pend_e;
    int            prob_c, prob_e;
    int            cpu_done_cnt, ext_done_cnt;
    int            last_cpu_done_cyc, last_ext_done_cyc;
    int            n_wr_obs;
    logic [NB-1:0] obs_wr_addr, obs_wr_data;

    task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_rem = 0; m_ext = 0; m_we = 0; m_wc = 0;
        m_addr = '0; m_wdata = '0; m_cpu_rd = '0; m_ext_rd = '0;
        pend_c = 0; pend_e = 0;
    endtask

    // One clock cycle: drive at posedge+1, compare and advance the model at negedge.
    task automatic step(input bit r);
        logic e_cd, e_ed, e_mr, e_mw;
        int   k;
        bit   ew;
        @(posedge clk); #1;
        rst = r;
        if (!pend_c && int'($urandom_range(99)) < prob_c) begin
            pend_c = 1; cpu_we = 1'($urandom_range(1));
            cpu_addr = {$urandom, $urandom}; cpu_wdata = {$urandom, $urandom};
        end
        if (!pend_e && int'($urandom_range(99)) < prob_e) begin
            pend_e = 1; ext_we = 1'($urandom_range(1));
            ext_addr = {$urandom, $urandom}; ext_wdata = {$urandom, $urandom};
        end
        cpu_req = pend_c;
        ext_req = pend_e;
        @(negedge clk);
        e_cd = 0; e_ed = 0; e_mr = 0; e_mw = 0;
        k = LAT + 1 - m_rem;
        if (m_rem > 0) begin
            if (k < LAT) begin
                e_mr = !m_we;
                e_mw = m_we && (k == 0);
            end else begin
                e_cd = !m_ext;
                e_ed = m_ext;
            end
        end
        chk1("cpu_done", cpu_done, e_cd);
        chk1("ext_done", ext_done, e_ed);
        chk1("mem_read", mem_read, e_mr);
        chk1("mem_write", mem_write, e_mw);
        chk1("cpu_stall", cpu_stall, cpu_req & ~e_cd);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("cpu_rdata", cpu_rdata, m_cpu_rd);
        chk("ext_rdata", ext_rdata, m_ext_rd);
        if (cpu_done === 1'b1) begin cpu_done_cnt++; last_cpu_done_cyc = cyc; end
        if (ext_done === 1'b1) begin ext_done_cnt++; last_ext_done_cyc = cyc; end
        if (mem_write === 1'b1) begin n_wr_obs++; obs_wr_addr = mem_addr; obs_wr_data = mem_wdata; end
        if (r) begin
            model_reset();
        end else if (m_rem > 0) begin
            if (k == LAT - 1 && !m_we) begin
                if (m_ext) m_ext_rd = fixed_mode ? fixed_rdata : mem_fn(m_addr);
                else       m_cpu_rd = fixed_mode ? fixed_rdata : mem_fn(m_addr);
            end
            if (k == LAT) begin
                if (m_ext) pend_e = 0;
                else       pend_c = 0;
            end
            m_rem--;
        end else if (cpu_req || ext_req) begin
            ew = ext_req && (!cpu_req || m_wc == MW);
            if (!ext_req || ew) m_wc = 0;
            else if (m_wc < MW) m_wc++;
            m_ext   = ew;
            m_we    = ew ? ext_we : cpu_we;
            m_addr  = ew ? ext_addr : cpu_addr;
            m_wdata = ew ? ext_wdata : cpu_wdata;
            m_rem   = LAT + 1;
        end else begin
            m_wc = 0;
        end
        cyc++;
    endtask

    task automatic drain();
        prob_c = 0; prob_e = 0;
        for (int i = 0; i < 40; i++) begin
            if (!pend_c && !pend_e && m_rem == 0) break;
            step(0);
        end
        chk("drain_idle", {62'b0, pend_c, pend_e}, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_cpu_done"}, cpu_done, 1'b0);
        chk1({tag, "_ext_done"}, ext_done, 1'b0);
        chk1({tag, "_mem_read"}, mem_read, 1'b0);
        chk1({tag, "_mem_write"}, mem_write, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, '0);
        chk({tag, "_mem_wdata"}, mem_wdata, '0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, '0);
        chk({tag, "_ext_rdata"}, ext_rdata, '0);
        chk1({tag, "_cpu_stall"}, cpu_stall, cpu_req);
    endtask

    task automatic rand_inputs();
        cpu_req = 1'($urandom_range(1)); cpu_we = 1'($urandom_range(1));
        ext_req = 1'($urandom_range(1)); ext_we = 1'($urandom_range(1));
        cpu_addr = {$urandom, $urandom}; cpu_wdata = {$urandom, $urandom};
        ext_addr = {$urandom, $urandom}; ext_wdata = {$urandom, $urandom};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, cd0, ed0;
        logic [NB-1:0] ext_rd_before;

        cpu_done_cnt = 0; ext_done_cnt = 0;
        last_cpu_done_cyc = -1; last_ext_done_cyc = -1;
        n_wr_obs = 0; obs_wr_addr = '0; obs_wr_data = '0;
        prob_c = 0; prob_e = 0;
        fixed_mode = 1; fixed_rdata = '0;
        model_reset();

        // 1. Reset held two cycles under random inputs
        rst = 1; rand_inputs();
        @(posedge clk); #1; rand_inputs();
        @(negedge clk); check_reset_outputs("rst1");
        @(posedge clk); #1; rand_inputs();
        @(negedge clk); check_reset_outputs("rst2");
        @(posedge clk); #1;
        rst = 0; cpu_req = 0; ext_req = 0;
        @(negedge clk);
        chk1("post_rst_idle_read", mem_read, 1'b0);
        step(0);
        step(0);

        // 2. CPU read of 0x10, memory returns 0xDEAD
        fixed_rdata = 64'hDEAD;
        pend_c = 1; cpu_we = 0; cpu_addr = 64'h10; cpu_wdata = '0;
        c0 = cyc; cd0 = cpu_done_cnt;
        repeat (4) step(0);
        chk_int("t2_done_cycle", last_cpu_done_cyc - c0, 3);
        chk_int("t2_done_count", cpu_done_cnt - cd0, 1);
        chk("t2_cpu_rdata", cpu_rdata, 64'hDEAD);

        // 3. Simultaneous requests: CPU first, ext follows
        fixed_rdata = 64'hBEEF;
        pend_c = 1; cpu_we = 0; cpu_addr = 64'h30; cpu_wdata = 64'h1;
        pend_e = 1; ext_we = 0; ext_addr = 64'h40; ext_wdata = 64'h2;
        c0 = cyc;
        repeat (8) step(0);
        chk_int("t3_cpu_done_cycle", last_cpu_done_cyc - c0, 3);
        chk_int("t3_ext_done_cycle", last_ext_done_cyc - c0, 7);
        chk("t3_ext_rdata", ext_rdata, 64'hBEEF);
        drain();

        // 4. Starvation: CPU wins four ties, ext the fifth, CPU the sixth
        fixed_mode = 0;
        prob_c = 100; prob_e = 100;
        c0 = cyc; cd0 = cpu_done_cnt; ed0 = ext_done_cnt;
        repeat (6 * (LAT + 2)) step(0);
        chk_int("t4_ext_done_cycle", last_ext_done_cyc - c0, 5 * (LAT + 2) - 1);
        chk_int("t4_cpu_done_count", cpu_done_cnt - cd0, 5);
        chk_int("t4_ext_done_count", ext_done_cnt - ed0, 1);
        drain();

        // 5. External write of 0x55 to 0x20
        pend_e = 1; ext_we = 1; ext_addr = 64'h20; ext_wdata = 64'h55;
        ext_rd_before = m_ext_rd;
        c0 = cyc; n_wr_obs = 0;
        repeat (4) step(0);
        chk_int("t5_write_pulses", n_wr_obs, 1);
        chk("t5_write_addr", obs_wr_addr, 64'h20);
        chk("t5_write_data", obs_wr_data, 64'h55);
        chk_int("t5_ext_done_cycle", last_ext_done_cyc - c0, 3);
        chk("t5_ext_rdata_kept", ext_rdata, ext_rd_before);
        step(0);

        // 6. Reset in the middle of a CPU read
        pend_c = 1; cpu_we = 0; cpu_addr = 64'h70; cpu_wdata = '0;
        cd0 = cpu_done_cnt;
        step(0);
        step(1);
        step(0);
        chk1("t6_mem_read_after_rst", mem_read, 1'b0);
        repeat (5) step(0);
        chk_int("t6_no_cpu_done", cpu_done_cnt - cd0, 0);
        chk("t6_cpu_rdata_cleared", cpu_rdata, '0);

        // 7. Random traffic from both requesters
        prob_c = 40; prob_e = 40;
        repeat (300) step(0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (memSys) between two requesters: the CPU MEM stage (requester 0) and an external loader/debug port (requester 1).
- Sequences each access over a fixed, multi-cycle memory latency and returns read data to the requester that issued it.
- Drives a stall to the pipeline while the CPU access is pending.
- Sits between the EX/MEM buffer outputs and memSys.

Parameters:
- Nbits, 64, address and data width.
- MEM_LAT, 2, memory access cycles per transaction; legal range >= 1.
- MAX_WAIT, 4, number of lost arbitrations after which the external port gets priority.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cpu_req  in  1  CPU access request; fields held stable until cpu_done
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  Nbits  CPU address
- cpu_wdata  in  Nbits  CPU write data
- cpu_rdata  out  Nbits  CPU read data; valid while cpu_done=1, then held
- cpu_done  out  1  one-cycle completion pulse to the CPU
- cpu_stall  out  1  pipeline freeze
- ext_req  in  1  external port request
- ext_we  in  1  1 = write, 0 = read
- ext_addr  in  Nbits  external address
- ext_wdata  in  Nbits  external write data
- ext_rdata  out  Nbits  external read data; valid while ext_done=1, then held
- ext_done  out  1  one-cycle completion pulse to the external port
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_addr  out  Nbits  memory address
- mem_wdata  out  Nbits  memory write data
- mem_rdata  in  Nbits  memory read data; valid in the last ACCESS cycle

Behaviour:
- Clocking and reset:
  - Single clock domain; clk and rst only.
  - rst is synchronous and active-high.
- Reset values:
  - State IDLE; lat_cnt = 0; wait_cnt = 0; owner = CPU.
  - All outputs 0, including both rdata registers.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Arbitration happens only in this state.
  - With no request, stay in IDLE.
  - If only one req is high, that requester wins.
  - If both are high: ext wins when wait_cnt == MAX_WAIT, otherwise the CPU wins.
  - The winner's we, addr and wdata are latched into internal registers and owner is set.
  - Next state ACCESS with lat_cnt = 0.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latched registers.
  - Reads: mem_read = 1 for all MEM_LAT cycles.
  - Writes: mem_write = 1 for the first ACCESS cycle only.
  - lat_cnt increments each cycle.
  - When lat_cnt == MEM_LAT-1:
    - For a read, mem_rdata is captured into the owner's rdata register.
    - Next state RESP.
  - lat_cnt width is $clog2(MEM_LAT+1); it never wraps.
- RESP:
  - Lasts exactly one cycle; next state IDLE.
  - The owner's done = 1 for that cycle.
  - For a write, the owner's rdata register is left unchanged.
- Latency and throughput:
  - From req sampled in IDLE to done: MEM_LAT+1 cycles.
  - Period between back-to-back transactions: MEM_LAT+2 cycles.
- Handshake:
  - A requester holds req and its fields stable until it sees done.
  - req high in any later IDLE cycle is a new request.
  - req dropped before done is illegal; the arbiter still completes the transaction.
- Outputs outside an access:
  - mem_read = 0 and mem_write = 0 outside ACCESS.
  - mem_addr and mem_wdata hold their last values.
- cpu_stall:
  - Combinational: cpu_stall = cpu_req & ~cpu_done.
  - Covers both the CPU waiting behind an ext transaction and the CPU's own access.
- Starvation counter (wait_cnt):
  - Evaluated in IDLE only.
  - Increments, saturating at MAX_WAIT, on each arbitration the CPU wins while ext_req = 1.
  - Clears when ext is granted, or in any IDLE cycle with ext_req = 0.
- Simultaneous events: a request arriving during ACCESS or RESP waits for IDLE; it is not lost, because req is held.
- Reset mid-operation:
  - The transaction is aborted; no done is issued.
  - mem_read and mem_write are 0 from the next cycle.
  - The memory may have already committed a write started before reset.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - typedef enum for arb_state_t {IDLE, ACCESS, RESP};
  - typedef enum for owner_t {OWN_CPU=1'b0, OWN_EXT=1'b1}.
- One sub-module, arb_priority:
  - Contains the winner selection and the wait_cnt saturating counter.
  - Inputs: clk, rst, arbitration-cycle enable, cpu_req, ext_req.
  - Outputs: grant_valid, grant_owner.

Test Plan (MEM_LAT=2, MAX_WAIT=4; cycle 0 = first IDLE cycle with req):
1. Reset: hold rst 2 cycles with random inputs -> all outputs 0; the FSM enters ACCESS only after rst drops and a req is seen.
2. CPU read of addr 0x10, mem_rdata = 0xDEAD in cycle 2:
   - mem_read = 1 in cycles 1-2 with mem_addr = 0x10.
   - cpu_done = 1 in cycle 3 with cpu_rdata = 0xDEAD.
   - cpu_stall = 1 in cycles 0-2 and 0 in cycle 3.
3. cpu_req and ext_req both high in cycle 0:
   - CPU done in cycle 3.
   - ext granted in IDLE cycle 4, mem_read in cycles 5-6, ext_done in cycle 7.
4. ext_req held while the CPU re-requests every IDLE -> the CPU wins 4 arbitrations (wait_cnt 1..4), ext wins the 5th, and wait_cnt returns to 0.
5. ext write, addr 0x20, data 0x55 -> mem_write = 1 for exactly one cycle with mem_addr = 0x20 and mem_wdata = 0x55; ext_done in cycle 3; ext_rdata unchanged.
6. rst asserted in cycle 1 of a CPU read -> mem_read = 0 in cycle 2, no cpu_done ever pulses, and cpu_rdata = 0.
